// File: rtl/dcpu_pkg.sv
// dcpu_pkg: constants and helpers shared by the DCPU fetch front end.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package dcpu_pkg;

  localparam int DEFAULT_AW = 32;

  // Leading bits that mark a multi-halfword instruction.
  localparam logic [2:0] LONG_PFX = 3'b111;
  // Second-level bits that extend a long instruction to three halfwords.
  localparam logic [1:0] EXT_PFX  = 2'b11;

  // Instruction length in halfwords (1..3), decoded from the first halfword.
  function automatic logic [1:0] insn_len(input logic [15:0] h);
    if (h[15:13] != LONG_PFX) begin
      insn_len = 2'd1;
    end else if (h[12:11] != EXT_PFX) begin
      insn_len = 2'd2;
    end else begin
      insn_len = 2'd3;
    end
  endfunction

endpackage

// File: rtl/dcpu_prefetch_fifo.sv
// dcpu_prefetch_fifo: halfword prefetch buffer, push 1 / peek 3 / pop 0..3 per cycle.
// Latency: a pushed halfword is visible on the peek ports the cycle after the push.
// Backpressure: none internally; the caller must not push when full or pop more than count.
// Ports: clk, flush (clears everything, overrides push/pop), push/push_dat, pop (entries
//        to drop from the head), count (0..DEPTH), peek0..peek2 (head and next two entries).
module dcpu_prefetch_fifo
  import dcpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     flush,
  input  logic                     push,
  input  logic [15:0]              push_dat,
  input  logic [1:0]               pop,
  output logic [$clog2(DEPTH):0]   count,
  output logic [15:0]              peek0,
  output logic [15:0]              peek1,
  output logic [15:0]              peek2
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [15:0]   mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;

  always_ff @(posedge clk) begin
    if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      rd_ptr <= rd_ptr + PW'(pop);
      count  <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two; entries past
  // count hold stale data and are ignored by the caller.
  assign peek0 = mem[rd_ptr];
  assign peek1 = mem[rd_ptr + PW'(1)];
  assign peek2 = mem[rd_ptr + PW'(2)];

endmodule

// File: rtl/dcpu_ifetch.sv
// dcpu_ifetch: halfword bus fetcher feeding a prefetch buffer; presents whole 1..3 halfword insns.
// Latency: an acked halfword enters the buffer in the ack cycle; one-halfword insn valid next cycle.
// Backpressure: i_ready low holds the presented insn; a full buffer drops o_cyc until a pop.
// Ports: i_clk/i_reset; bus master o_cyc/o_stb/o_we/o_addr/o_dat with i_ack/i_dat;
//        i_redirect/i_redirect_pc restart fetch; decoder side o_valid/i_ready/o_ir/o_imm/o_len/o_pc.
module dcpu_ifetch
  import dcpu_pkg::*;
#(
  parameter int            AW       = DEFAULT_AW,
  parameter int            DEPTH    = 4,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic          i_clk,
  input  logic          i_reset,
  output logic          o_cyc,
  output logic [1:0]    o_stb,
  output logic          o_we,
  output logic [AW-1:0] o_addr,
  output logic [15:0]   o_dat,
  input  logic          i_ack,
  input  logic [15:0]   i_dat,
  input  logic          i_redirect,
  input  logic [AW-1:0] i_redirect_pc,
  output logic          o_valid,
  input  logic          i_ready,
  output logic [15:0]   o_ir,
  output logic [31:0]   o_imm,
  output logic [1:0]    o_len,
  output logic [AW-1:0] o_pc
);

  localparam int            CW   = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [AW-1:0] fa;
  logic [AW-1:0] pc;
  logic [AW-1:0] redirect_tgt;
  logic [CW-1:0] count;
  logic [15:0]   e0;
  logic [15:0]   e1;
  logic [15:0]   e2;
  logic [1:0]    len;
  logic          push;
  logic          take;
  logic          flush;
  logic [1:0]    pop;

  // Fetch request: the only term that can drop it while a cycle is pending
  // is redirect/reset, since count only falls (pop) or rises on an ack.
  assign o_cyc  = (count < FULL) && !i_redirect && !i_reset;
  assign o_stb  = {2{o_cyc}};
  assign o_we   = 1'b0;
  assign o_dat  = '0;
  assign o_addr = fa;

  assign push  = o_cyc && i_ack;
  assign flush = i_reset || i_redirect;

  assign len     = insn_len(e0);
  assign o_valid = !i_reset && (count >= CW'(len));
  // Redirect wins over a same-cycle accept, so nothing is popped then.
  assign take    = o_valid && i_ready && !i_redirect;
  assign pop     = take ? len : 2'd0;

  assign redirect_tgt = i_redirect_pc & ~AW'(1);

  dcpu_prefetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (i_clk),
    .flush    (flush),
    .push     (push),
    .push_dat (i_dat),
    .pop      (pop),
    .count    (count),
    .peek0    (e0),
    .peek1    (e1),
    .peek2    (e2)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      fa <= RESET_PC;
      pc <= RESET_PC;
    end else if (i_redirect) begin
      fa <= redirect_tgt;
      pc <= redirect_tgt;
    end else begin
      if (push) begin
        fa <= fa + AW'(2);
      end
      if (take) begin
        pc <= pc + AW'({len, 1'b0});
      end
    end
  end

  always_comb begin
    o_imm = 32'h0;
    case (len)
      2'd2:    o_imm = {16'h0, e1};
      2'd3:    o_imm = {e2, e1};
      default: o_imm = 32'h0;
    endcase
  end

  assign o_ir  = e0;
  assign o_len = len;
  assign o_pc  = pc;

endmodule

// File: doc/dcpu_ifetch.md
DCPU_IFETCH -- requirements
Module: dcpu_ifetch

Interface
REQ-001 SHALL have parameters, one per line:
- AW, 32, fetch address width.
- DEPTH, 4, prefetch buffer depth in halfwords; power of two, >=4.
- RESET_PC, 0, fetch/instruction address after reset; bit 0 = 0.

REQ-002 SHALL have ports, one per line:
- i_clk  in  1  clock.
- i_reset  in  1  reset; synchronous, active-high.
- o_cyc  out  1  bus cycle active.
- o_stb  out  2  byte strobes.
- o_we  out  1  write enable; constant 0.
- o_addr  out  AW  halfword fetch address.
- o_dat  out  16  write data; constant 0.
- i_ack  in  1  bus acknowledge; i_dat valid.
- i_dat  in  16  read data.
- i_redirect  in  1  flush and restart fetch.
- i_redirect_pc  in  AW  new instruction address.
- o_valid  out  1  complete instruction presented.
- i_ready  in  1  decoder accepts instruction.
- o_ir  out  16  first instruction halfword.
- o_imm  out  32  immediate, zero-extended.
- o_len  out  2  instruction length in halfwords (1..3).
- o_pc  out  AW  address of presented instruction.

Function
REQ-003 Length decode of halfword h SHALL be: h[15:13]!=3'b111 -> 1; h[15:13]==3'b111 and h[12:11]!=2'b11 -> 2; h[12:11]==2'b11 -> 3.
REQ-004 Buffer SHALL hold up to DEPTH halfwords in fetch order; count range 0..DEPTH.
REQ-005 o_cyc SHALL be combinational: 1 iff count<DEPTH and !i_redirect and !i_reset; o_stb = {2{o_cyc}}.
REQ-006 o_addr SHALL equal fetch address register fa; fa SHALL advance by 2 (mod 2^AW) on each cycle with o_cyc && i_ack.
REQ-007 An acked halfword SHALL be written to the buffer in the ack cycle; zero-wait ack SHALL sustain 1 halfword/cycle.
REQ-008 Once o_cyc rises it SHALL stay high until i_ack or i_redirect (count cannot rise without ack).
REQ-009 o_valid SHALL be 1 iff count>=len(head); o_ir=head, o_len=len(head).
REQ-010 o_imm SHALL be {16'h0, entry1} for len 2, {entry2, entry1} for len 3, 0 for len 1.
REQ-011 o_ir/o_imm/o_len/o_pc SHALL be held stable while o_valid && !i_ready.
REQ-012 On o_valid && i_ready, buffer SHALL pop o_len entries and o_pc SHALL advance by 2*o_len (mod 2^AW) next cycle.
REQ-013 Simultaneous push and pop SHALL yield count_next = count + push - o_len; no entry lost or duplicated.
REQ-014 i_redirect SHALL take priority over push and pop: count<=0, fa<=i_redirect_pc with bit 0 forced 0, o_pc<=same; ack in that cycle discarded; o_valid=0 next cycle.
REQ-015 Redirect while a bus cycle is pending SHALL abort it (o_cyc low during the redirect cycle); fetch restarts at new fa next cycle.
REQ-016 Buffer full (count==DEPTH) SHALL hold o_cyc low until a pop frees space.
REQ-017 Address wrap: fa and o_pc SHALL wrap from 2^AW-2 to 0 without error.

Reset
REQ-018 While i_reset: count=0, fa=o_pc=RESET_PC, o_valid=0, o_cyc=0, o_stb=0; o_imm/o_ir/o_len don't-care while o_valid=0.
REQ-019 First cycle after reset release SHALL assert o_cyc with o_addr=RESET_PC.
REQ-020 Reset mid-cycle SHALL abort the pending bus cycle and discard buffered data.

Structure
REQ-021 Shared package dcpu_pkg SHALL hold the prefix constants (3'b111, 2'b11), the length-decode function and default AW.
REQ-022 Buffer SHALL be sub-module dcpu_prefetch_fifo (push 1, peek 3, pop 0..3, flush).

Verification
REQ-023 Reset, zero-wait memory with halfwords 0x1234,0xE001,0xAAAA,0xF801,0x5678,0x9ABC -> insns: (0x1234,len1,pc0), (0xE001,imm 0x0000AAAA,len2,pc2), (0xF801,imm 0x9ABC5678,len3,pc6).
REQ-024 i_ready=0 with DEPTH=4 -> exactly 4 acks, o_cyc low, outputs stable; i_ready=1 -> fetching resumes at 0x8.
REQ-025 Ack delayed 3 cycles each -> o_addr stable and o_cyc high until ack; decoded stream identical to REQ-023.
REQ-026 i_redirect to 0x1001 during pending fetch -> o_cyc low one cycle, next o_addr=0x1000, first accepted o_pc=0x1000, no stale instruction.
REQ-027 Redirect to 0xFFFFFFFC with 1-halfword insns -> o_pc sequence 0xFFFFFFFC, 0xFFFFFFFE, 0x0.
REQ-028 i_reset asserted mid-3-halfword fetch -> o_valid=0 next cycle, fetch restarts at RESET_PC.
